// File: rtl/rename_stage.sv
// Purpose : register-rename stage; maps logical rs1/rs2/rd of up to NUM_OF_FETCH lanes onto
//           physical registers via a speculative map (RAT), restored from a committed map (RRAT) on flush.
// Latency : 1 cycle from an accepted group to out_valid.
// Backpr. : all-or-nothing group accept; in_ready drops while the output register is held
//           (out_ready=0) or the free list lacks enough proposals; flush blocks acceptance that cycle.
// Ports   :
//   clock, reset (sync, active-low)
//   in_valid/in_rs1/in_rs2/in_rd/in_rd_valid [F] : decode group; in_ready : group accepted
//   available_prd[F] : free-list proposals (0 = empty slot); prd_used[F] : slots consumed (by slot)
//   out_valid/out_prs1/out_prs2/out_prd/out_prev_prd/out_rd_valid [F], out_ready : dispatch side
//   committed_rd_valid/committed_rd/committed_phyreg [G] : graduation writes into RRAT
//   flush_in : restore RAT from RRAT, drop output register contents
module rename_stage #(
  parameter int NUM_OF_FETCH    = 4,
  parameter int NUM_OF_GRADUATE = 4,
  parameter int NUM_OF_LOGREGS  = 32,
  parameter int NUM_OF_PHYREGS  = 96,
  localparam int F  = NUM_OF_FETCH,
  localparam int G  = NUM_OF_GRADUATE,
  localparam int PW = $clog2(NUM_OF_PHYREGS),
  localparam int LW = $clog2(NUM_OF_LOGREGS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [F-1:0]         in_valid,
  input  logic [F-1:0][LW-1:0] in_rs1,
  input  logic [F-1:0][LW-1:0] in_rs2,
  input  logic [F-1:0][LW-1:0] in_rd,
  input  logic [F-1:0]         in_rd_valid,
  output logic                 in_ready,
  input  logic [F-1:0][PW-1:0] available_prd,
  output logic [F-1:0]         prd_used,
  output logic [F-1:0]         out_valid,
  output logic [F-1:0][PW-1:0] out_prs1,
  output logic [F-1:0][PW-1:0] out_prs2,
  output logic [F-1:0][PW-1:0] out_prd,
  output logic [F-1:0][PW-1:0] out_prev_prd,
  output logic [F-1:0]         out_rd_valid,
  input  logic                 out_ready,
  input  logic [G-1:0]         committed_rd_valid,
  input  logic [G-1:0][LW-1:0] committed_rd,
  input  logic [G-1:0][PW-1:0] committed_phyreg,
  input  logic                 flush_in
);

  // Count width must hold the value F itself (all lanes allocating).
  localparam int CW = $clog2(F + 1);

  logic [PW-1:0] rat      [NUM_OF_LOGREGS];
  logic [PW-1:0] rrat     [NUM_OF_LOGREGS];
  logic [PW-1:0] rat_nxt  [NUM_OF_LOGREGS];
  logic [PW-1:0] rrat_nxt [NUM_OF_LOGREGS];

  logic [F-1:0]         alloc;
  logic [CW-1:0]        n_alloc;
  logic [F-1:0][PW-1:0] lane_prd;
  logic [F-1:0][PW-1:0] lane_prs1;
  logic [F-1:0][PW-1:0] lane_prs2;
  logic [F-1:0][PW-1:0] lane_prev;
  logic                 enough_regs;
  logic                 fire;

  // Allocation: the k-th allocating lane (in lane order) takes proposal slot k.
  always_comb begin
    n_alloc  = '0;
    alloc    = '0;
    lane_prd = '0;
    for (int j = 0; j < F; j++) begin
      alloc[j] = in_valid[j] & in_rd_valid[j] & (in_rd[j] != '0);
      if (alloc[j]) begin
        for (int k = 0; k < F; k++) begin
          if (n_alloc == CW'(k)) lane_prd[j] = available_prd[k];
        end
        n_alloc = n_alloc + CW'(1);
      end
    end
  end

  // Free list fills slots in order, so checking the last needed slot covers all earlier ones.
  always_comb begin
    enough_regs = (n_alloc == '0);
    for (int k = 0; k < F; k++) begin
      if (n_alloc == CW'(k + 1)) enough_regs = (available_prd[k] != '0);
    end
    in_ready = reset & ~flush_in & (~(|out_valid) | out_ready) & enough_regs;
    fire     = in_ready & (|in_valid);
    prd_used = '0;
    for (int k = 0; k < F; k++) begin
      prd_used[k] = fire & (CW'(k) < n_alloc);
    end
  end

  // Source and previous-mapping lookup with intra-group bypass. Scanning older lanes in
  // ascending order lets the youngest matching older lane win.
  always_comb begin
    for (int j = 0; j < F; j++) begin
      lane_prs1[j] = rat[in_rs1[j]];
      lane_prs2[j] = rat[in_rs2[j]];
      lane_prev[j] = rat[in_rd[j]];
      for (int i = 0; i < j; i++) begin
        if (alloc[i] && (in_rd[i] == in_rs1[j])) lane_prs1[j] = lane_prd[i];
        if (alloc[i] && (in_rd[i] == in_rs2[j])) lane_prs2[j] = lane_prd[i];
        if (alloc[i] && (in_rd[i] == in_rd[j]))  lane_prev[j] = lane_prd[i];
      end
      if (in_rs1[j] == '0) lane_prs1[j] = '0;
      if (in_rs2[j] == '0) lane_prs2[j] = '0;
      if (!alloc[j])       lane_prev[j] = '0;
    end
  end

  // Committed map: highest port applied last so it wins on equal rd.
  always_comb begin
    rrat_nxt = rrat;
    for (int g = 0; g < G; g++) begin
      if (committed_rd_valid[g] && (committed_rd[g] != '0)) rrat_nxt[committed_rd[g]] = committed_phyreg[g];
    end
  end

  // Speculative map: flush restores including this cycle's commits; youngest lane wins on equal rd.
  always_comb begin
    rat_nxt = rat;
    if (flush_in) begin
      rat_nxt = rrat_nxt;
    end else if (fire) begin
      for (int j = 0; j < F; j++) begin
        if (alloc[j]) rat_nxt[in_rd[j]] = lane_prd[j];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_OF_LOGREGS; i++) begin
        rat[i]  <= PW'(i);
        rrat[i] <= PW'(i);
      end
    end else begin
      rat  <= rat_nxt;
      rrat <= rrat_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid    <= '0;
      out_prs1     <= '0;
      out_prs2     <= '0;
      out_prd      <= '0;
      out_prev_prd <= '0;
      out_rd_valid <= '0;
    end else if (flush_in) begin
      out_valid <= '0;
    end else if (fire) begin
      out_valid    <= in_valid;
      out_prs1     <= lane_prs1;
      out_prs2     <= lane_prs2;
      out_prd      <= lane_prd;
      out_prev_prd <= lane_prev;
      out_rd_valid <= alloc;
    end else if (out_ready) begin
      out_valid <= '0;
    end
  end

endmodule

// File: tb/tb_rename_stage.sv
module tb_rename_stage;

  localparam int F  = 4;
  localparam int G  = 4;
  localparam int PW = 7;
  localparam int LW = 5;

  logic                 clock;
  logic                 reset;
  logic [F-1:0]         in_valid;
  logic [F-1:0][LW-1:0] in_rs1;
  logic [F-1:0][LW-1:0] in_rs2;
  logic [F-1:0][LW-1:0] in_rd;
  logic [F-1:0]         in_rd_valid;
  logic                 in_ready;
  logic [F-1:0][PW-1:0] available_prd;
  logic [F-1:0]         prd_used;
  logic [F-1:0]         out_valid;
  logic [F-1:0][PW-1:0] out_prs1;
  logic [F-1:0][PW-1:0] out_prs2;
  logic [F-1:0][PW-1:0] out_prd;
  logic [F-1:0][PW-1:0] out_prev_prd;
  logic [F-1:0]         out_rd_valid;
  logic                 out_ready;
  logic [G-1:0]         committed_rd_valid;
  logic [G-1:0][LW-1:0] committed_rd;
  logic [G-1:0][PW-1:0] committed_phyreg;
  logic                 flush_in;

  rename_stage #(
    .NUM_OF_FETCH(F), .NUM_OF_GRADUATE(G), .NUM_OF_LOGREGS(32), .NUM_OF_PHYREGS(96)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_valid(in_rd_valid),
    .in_ready(in_ready), .available_prd(available_prd), .prd_used(prd_used),
    .out_valid(out_valid), .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd(out_prd),
    .out_prev_prd(out_prev_prd), .out_rd_valid(out_rd_valid), .out_ready(out_ready),
    .committed_rd_valid(committed_rd_valid), .committed_rd(committed_rd),
    .committed_phyreg(committed_phyreg), .flush_in(flush_in)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model state: architectural maps as plain integer arrays plus expected output register.
  int       m_rat  [32];
  int       m_rrat [32];
  int       nx_rrat[32];
  int       tmp_map[32];
  bit [3:0] e_valid;
  bit [3:0] e_rdv;
  int       e_prs1[4];
  int       e_prs2[4];
  int       e_prd [4];
  int       e_prev[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int count_alloc();
    int n = 0;
    for (int j = 0; j < F; j++)
      if (in_valid[j] && in_rd_valid[j] && in_rd[j] != 0) n++;
    return n;
  endfunction

  function automatic bit model_ready();
    int n = count_alloc();
    bit regs_ok = (n == 0) || (available_prd[n-1] != 0);
    return reset && !flush_in && (e_valid == 0 || out_ready) && regs_ok;
  endfunction

  function automatic logic [3:0] model_used();
    logic [3:0] u = '0;
    int n = count_alloc();
    if (model_ready() && in_valid != 0)
      for (int k = 0; k < n; k++) u[k] = 1'b1;
    return u;
  endfunction

  // Model update: rename the group lane by lane against a running copy of the map, so
  // intra-group dependencies fall out of sequential program order.
  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin m_rat[i] = i; m_rrat[i] = i; end
      e_valid = '0;
      e_rdv   = '0;
      for (int j = 0; j < 4; j++) begin e_prs1[j] = 0; e_prs2[j] = 0; e_prd[j] = 0; e_prev[j] = 0; end
    end else begin
      nx_rrat = m_rrat;
      for (int g = 0; g < G; g++)
        if (committed_rd_valid[g] && committed_rd[g] != 0) nx_rrat[committed_rd[g]] = int'(committed_phyreg[g]);
      if (flush_in) begin
        m_rat   = nx_rrat;
        e_valid = '0;
      end else if (model_ready() && in_valid != 0) begin
        int k;
        k = 0;
        tmp_map = m_rat;
        for (int j = 0; j < F; j++) begin
          e_prs1[j] = (in_rs1[j] == 0) ? 0 : tmp_map[in_rs1[j]];
          e_prs2[j] = (in_rs2[j] == 0) ? 0 : tmp_map[in_rs2[j]];
          if (in_valid[j] && in_rd_valid[j] && in_rd[j] != 0) begin
            e_prev[j] = tmp_map[in_rd[j]];
            e_prd[j]  = int'(available_prd[k]);
            k++;
            tmp_map[in_rd[j]] = e_prd[j];
            e_rdv[j] = 1'b1;
          end else begin
            e_prev[j] = 0;
            e_prd[j]  = 0;
            e_rdv[j]  = 1'b0;
          end
        end
        e_valid = in_valid;
        m_rat   = tmp_map;
      end else if (out_ready) begin
        e_valid = '0;
      end
      m_rrat = nx_rrat;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("in_ready", in_ready, model_ready());
      chk("prd_used", prd_used, model_used());
      chk("out_valid", out_valid, e_valid);
      for (int j = 0; j < F; j++) begin
        if (e_valid[j]) begin
          chk("out_prs1", out_prs1[j], e_prs1[j]);
          chk("out_prs2", out_prs2[j], e_prs2[j]);
          chk("out_prd", out_prd[j], e_prd[j]);
          chk("out_prev_prd", out_prev_prd[j], e_prev[j]);
          chk("out_rd_valid", out_rd_valid[j], e_rdv[j]);
        end
      end
    end
  end

  task automatic idle();
    in_valid = '0; in_rd_valid = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    available_prd = '0; committed_rd_valid = '0; committed_rd = '0; committed_phyreg = '0;
    flush_in = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    out_ready = 1'b1;
    idle();
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_prd", out_prd, 0);
    chk("rst_out_prs1", out_prs1, 0);
    chk("rst_out_prev", out_prev_prd, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_prd_used", prd_used, 0);
    chk_en = 1'b1;
    reset = 1'b1;

    // 1) four allocations straight after reset
    in_valid = 4'hF; in_rd_valid = 4'hF;
    for (int j = 0; j < F; j++) begin in_rd[j] = LW'(j + 1); available_prd[j] = PW'(32 + j); end
    #1;
    chk("t1_ready", in_ready, 1);
    chk("t1_used", prd_used, 4'b1111);
    step();
    chk("t1_valid", out_valid, 4'hF);
    for (int j = 0; j < F; j++) begin
      chk("t1_prd", out_prd[j], 32 + j);
      chk("t1_prev", out_prev_prd[j], j + 1);
    end

    // 2) intra-group bypass on x5
    idle();
    in_valid = 4'b0111; in_rd_valid = 4'b0011;
    in_rd[0] = 5; in_rs1[1] = 5; in_rd[1] = 5; in_rs2[2] = 5;
    available_prd[0] = 40; available_prd[1] = 41;
    #1;
    chk("t2_used", prd_used, 4'b0011);
    step();
    chk("t2_prev0", out_prev_prd[0], 5);
    chk("t2_prs1_l1", out_prs1[1], 40);
    chk("t2_prev_l1", out_prev_prd[1], 40);
    chk("t2_prs2_l2", out_prs2[2], 41);
    chk("t2_prd_l2", out_prd[2], 0);
    chk("t2_rdv", out_rd_valid, 4'b0011);

    // 3) short free list stalls the whole group
    idle();
    in_valid = 4'b0111; in_rd_valid = 4'b0111;
    in_rd[0] = 10; in_rd[1] = 11; in_rd[2] = 12; in_rs1[0] = 5;
    available_prd[0] = 40; available_prd[1] = 41;
    #1;
    chk("t3_ready_stall", in_ready, 0);
    chk("t3_used_stall", prd_used, 0);
    step();
    available_prd[2] = 42;
    #1;
    chk("t3_ready", in_ready, 1);
    chk("t3_used", prd_used, 4'b0111);
    step();
    chk("t3_prs1_x5", out_prs1[0], 41);
    for (int j = 0; j < 3; j++) begin
      chk("t3_prd", out_prd[j], 40 + j);
      chk("t3_prev", out_prev_prd[j], 10 + j);
    end

    // 4) output held under backpressure, then released
    idle();
    out_ready = 1'b0;
    in_valid = 4'b0001; in_rd_valid = 4'b0001; in_rd[0] = 13; available_prd[0] = 45;
    #1;
    chk("t4_ready_held", in_ready, 0);
    step();
    chk("t4_held_valid", out_valid, 4'b0111);
    chk("t4_held_prd", out_prd[0], 40);
    out_ready = 1'b1;
    #1;
    chk("t4_ready", in_ready, 1);
    step();
    chk("t4_valid", out_valid, 4'b0001);
    chk("t4_prd", out_prd[0], 45);
    chk("t4_prev", out_prev_prd[0], 13);

    // 5) flush restores the committed mapping of x7
    idle();
    in_valid = 4'b0001; in_rd_valid = 4'b0001; in_rd[0] = 7; available_prd[0] = 50;
    step();
    committed_rd_valid[0] = 1'b1; committed_rd[0] = 7; committed_phyreg[0] = 50;
    available_prd[0] = 60;
    step();
    chk("t5_prd60", out_prd[0], 60);
    chk("t5_prev50", out_prev_prd[0], 50);
    idle();
    flush_in = 1'b1;
    in_valid = 4'b0001; in_rd_valid = 4'b0001; in_rd[0] = 8; available_prd[0] = 61;
    #1;
    chk("t5_flush_ready", in_ready, 0);
    chk("t5_flush_used", prd_used, 0);
    step();
    chk("t5_flush_valid", out_valid, 0);
    idle();
    in_valid = 4'b0001; in_rs1[0] = 7;
    #1;
    chk("t5_ready_after", in_ready, 1);
    step();
    chk("t5_prs1_x7", out_prs1[0], 50);

    // 6) flush with same-cycle commits; x0 lane never allocates
    idle();
    flush_in = 1'b1;
    committed_rd_valid = 4'b1011;
    committed_rd[0] = 0; committed_phyreg[0] = 77;
    committed_rd[1] = 9; committed_phyreg[1] = 71;
    committed_rd[3] = 9; committed_phyreg[3] = 70;
    step();
    idle();
    in_valid = 4'b0011; in_rd_valid = 4'b0001;
    in_rs1[0] = 9; in_rd[0] = 0; in_rs2[1] = 9;
    #1;
    chk("t6_ready", in_ready, 1);
    chk("t6_used", prd_used, 0);
    step();
    chk("t6_prs1_x9", out_prs1[0], 70);
    chk("t6_prs2_x0", out_prs2[0], 0);
    chk("t6_prs2_l1", out_prs2[1], 70);
    chk("t6_rdv", out_rd_valid, 0);
    chk("t6_prd", out_prd[0], 0);

    // Randomised traffic checked every cycle against the model
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 199) != 0);
      flush_in  = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid    = 4'($urandom);
      in_rd_valid = 4'($urandom);
      for (int j = 0; j < F; j++) begin
        in_rs1[j] = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 31)) : LW'($urandom_range(0, 7));
        in_rs2[j] = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 31)) : LW'($urandom_range(0, 7));
        in_rd[j]  = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 31)) : LW'($urandom_range(0, 7));
        available_prd[j] = ($urandom_range(0, 7) == 0) ? PW'(0) : PW'($urandom_range(32, 95));
      end
      committed_rd_valid = 4'($urandom);
      for (int g = 0; g < G; g++) begin
        committed_rd[g]     = LW'($urandom_range(0, 7));
        committed_phyreg[g] = PW'($urandom_range(1, 95));
      end
      step();
    end
    reset = 1'b1;
    idle();
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
